// File: rtl/wb_pkg.sv
// Shared widths, writeback source-select encodings and clear-FSM state type.
package wb_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NWIN   = 4;
  localparam int unsigned NREG   = 4;

  // RegDatao4 source-select encodings
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_REGB = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } wb_state_e;

endpackage

// File: rtl/regfile_array.sv
// Register storage: one write port, one single-word clear port, two async read ports.
module regfile_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage update; the write port is applied after the clear so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (clr) begin
        mem_q[clr_addr] <= '0;
      end
      if (we) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/writeback_regfile.sv
// Windowed writeback register file with read bypass and a background window-clear engine.
module writeback_regfile #(
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned NWIN   = wb_pkg::NWIN,
  parameter int unsigned NREG   = wb_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             Instout,
  input  logic [DATA_W-1:0]       W4,
  input  logic [DATA_W-1:0]       Memoryout,
  input  logic [DATA_W-1:0]       Regbout,
  input  logic                    RegWriteo4,
  input  logic [1:0]              RegDatao4,
  input  logic [$clog2(NWIN)-1:0] WindowRout,
  input  logic                    clr_win,
  input  logic [$clog2(NWIN)-1:0] clr_idx,
  input  logic [$clog2(NWIN)-1:0] ra_win,
  input  logic [$clog2(NREG)-1:0] ra_idx,
  input  logic [$clog2(NWIN)-1:0] rb_win,
  input  logic [$clog2(NREG)-1:0] rb_idx,
  output logic [DATA_W-1:0]       Regaout,
  output logic [DATA_W-1:0]       Regbrd,
  output logic [DATA_W-1:0]       wb_data,
  output logic                    wb_valid,
  output logic                    busy
);

  import wb_pkg::*;

  localparam int unsigned WIN_BITS  = $clog2(NWIN);
  localparam int unsigned IDX_BITS  = $clog2(NREG);
  localparam int unsigned ADDR_BITS = WIN_BITS + IDX_BITS;

  wb_state_e             state_q, state_d;
  logic [IDX_BITS-1:0]   cnt_q, cnt_d;
  logic [WIN_BITS-1:0]   win_q, win_d;
  logic                  clr_en;
  logic [ADDR_BITS-1:0]  waddr, clr_addr, raddr_a, raddr_b;
  logic [DATA_W-1:0]     rdata_a, rdata_b;

  // Only the destination index field of the instruction is used here.
  logic unused_instout;
  assign unused_instout = ^{Instout[15:4], Instout[1:0]};

  // Writeback source select; the reserved code yields zero and never writes.
  always_comb begin
    wb_data  = '0;
    wb_valid = 1'b0;
    unique case (RegDatao4)
      SEL_ALU:  wb_data = W4;
      SEL_MEM:  wb_data = Memoryout;
      SEL_REGB: wb_data = Regbout;
      SEL_NONE: wb_data = '0;
      default:  wb_data = '0;
    endcase
    wb_valid = RegWriteo4 && (RegDatao4 != SEL_NONE);
  end

  assign waddr   = {WindowRout, Instout[3:2]};
  assign raddr_a = {ra_win, ra_idx};
  assign raddr_b = {rb_win, rb_idx};

  // Clear FSM state, counter and latched window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  // Clear next-state: walk the latched window one register per cycle; new requests are ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    clr_en   = 1'b0;
    clr_addr = {win_q, cnt_q};
    unique case (state_q)
      StIdle: begin
        if (clr_win) begin
          state_d = StClear;
          win_d   = clr_idx;
          cnt_d   = '0;
        end
      end
      StClear: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IDX_BITS'(NREG - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StClear);

  regfile_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_valid),
    .waddr    (waddr),
    .wdata    (wb_data),
    .clr      (clr_en),
    .clr_addr (clr_addr),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b)
  );

  // Read ports forward the in-flight writeback when addresses match.
  always_comb begin
    Regaout = (wb_valid && (raddr_a == waddr)) ? wb_data : rdata_a;
    Regbrd  = (wb_valid && (raddr_b == waddr)) ? wb_data : rdata_b;
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with a reference model and a writeback scoreboard.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Instout = '0;
  logic [15:0] W4 = '0;
  logic [15:0] Memoryout = '0;
  logic [15:0] Regbout = '0;
  logic        RegWriteo4 = 1'b0;
  logic [1:0]  RegDatao4 = '0;
  logic [1:0]  WindowRout = '0;
  logic        clr_win = 1'b0;
  logic [1:0]  clr_idx = '0;
  logic [1:0]  ra_win = '0;
  logic [1:0]  ra_idx = '0;
  logic [1:0]  rb_win = '0;
  logic [1:0]  rb_idx = '0;
  logic [15:0] Regaout;
  logic [15:0] Regbrd;
  logic [15:0] wb_data;
  logic        wb_valid;
  logic        busy;

  always #50 clk = ~clk;

  writeback_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .Instout    (Instout),
    .W4         (W4),
    .Memoryout  (Memoryout),
    .Regbout    (Regbout),
    .RegWriteo4 (RegWriteo4),
    .RegDatao4  (RegDatao4),
    .WindowRout (WindowRout),
    .clr_win    (clr_win),
    .clr_idx    (clr_idx),
    .ra_win     (ra_win),
    .ra_idx     (ra_idx),
    .rb_win     (rb_win),
    .rb_idx     (rb_idx),
    .Regaout    (Regaout),
    .Regbrd     (Regbrd),
    .wb_data    (wb_data),
    .wb_valid   (wb_valid),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the array and the clear engine
  logic [15:0] model [16];
  bit          m_clr = 0;
  int          m_cnt = 0;
  int          m_win = 0;

  // Scoreboard of committed writebacks awaiting array read-back
  int          exp_addr_q [$];
  logic [15:0] exp_data_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, updating the model with the inputs present before the edge.
  task automatic tick();
    bit          wv;
    logic [15:0] wd;
    int          wa;
    wv = RegWriteo4 && (RegDatao4 != 2'b11);
    case (RegDatao4)
      2'b00:   wd = W4;
      2'b01:   wd = Memoryout;
      2'b10:   wd = Regbout;
      default: wd = 16'h0000;
    endcase
    wa = int'(WindowRout) * 4 + int'(Instout[3:2]);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      m_clr = 0;
      m_cnt = 0;
    end else begin
      if (m_clr) begin
        model[m_win * 4 + m_cnt] = 16'h0000;
        if (m_cnt == 3) m_clr = 0;
        m_cnt = (m_cnt + 1) % 4;
      end else if (clr_win) begin
        m_clr = 1;
        m_win = int'(clr_idx);
        m_cnt = 0;
      end
      if (wv) model[wa] = wd;
    end
    #1;
  endtask

  task automatic set_ra(input int a);
    ra_win = 2'(a / 4);
    ra_idx = 2'(a % 4);
  endtask

  task automatic set_rb(input int a);
    rb_win = 2'(a / 4);
    rb_idx = 2'(a % 4);
  endtask

  // Drive a writeback for the next edge; pushes the expected array content when it should commit.
  task automatic drive_wb(input int win, input int idx, input logic [1:0] sel,
                          input logic [15:0] val);
    logic [1:0] i2;
    i2         = 2'(idx);
    Instout    = {12'h000, i2, 2'b00};
    WindowRout = 2'(win);
    RegDatao4  = sel;
    W4         = (sel == 2'b00) ? val : 16'h0F0F;
    Memoryout  = (sel == 2'b01) ? val : 16'h1E1E;
    Regbout    = (sel == 2'b10) ? val : 16'h2D2D;
    RegWriteo4 = 1'b1;
    if (sel != 2'b11) begin
      exp_addr_q.push_back(win * 4 + idx);
      exp_data_q.push_back(val);
    end
  endtask

  task automatic idle_wb();
    RegWriteo4 = 1'b0;
    RegDatao4  = 2'b00;
  endtask

  // Pop every committed writeback and confirm the array holds it.
  task automatic drain(input string tag);
    int          a;
    logic [15:0] d;
    while (exp_addr_q.size() > 0) begin
      a = exp_addr_q.pop_front();
      d = exp_data_q.pop_front();
      set_ra(a);
      #1;
      check(tag, 32'(Regaout), 32'(d));
    end
  endtask

  // Read every address on both ports (no writeback in flight) against the model.
  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      set_ra(i);
      set_rb(15 - i);
      #1;
      check({tag, "_a"}, 32'(Regaout), 32'(model[i]));
      check({tag, "_b"}, 32'(Regbrd), 32'(model[15 - i]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      set_ra(i);
      set_rb(i);
      #1;
      check({tag, "_a"}, 32'(Regaout), 32'h0);
      check({tag, "_b"}, 32'(Regbrd), 32'h0);
    end
  endtask

  task automatic fill_window(input int win, input logic [15:0] val);
    for (int k = 0; k < 4; k++) begin
      drive_wb(win, k, 2'b00, val);
      tick();
    end
    idle_wb();
  endtask

  initial begin
    int waited;
    for (int i = 0; i < 16; i++) model[i] = 16'hxxxx;

    // Reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'h0);
    check_all_zero("reset_rd");

    // ALU writeback with same-cycle bypass on both ports
    drive_wb(1, 2, 2'b00, 16'h1234);
    set_ra(6);
    set_rb(6);
    #1;
    check("alu_wb_valid", 32'(wb_valid), 32'h1);
    check("alu_wb_data", 32'(wb_data), 32'h1234);
    check("alu_bypass_a", 32'(Regaout), 32'h1234);
    check("alu_bypass_b", 32'(Regbrd), 32'h1234);
    tick();
    idle_wb();
    drain("alu_array");

    // Memory and register-B sources
    drive_wb(0, 3, 2'b01, 16'hBEEF);
    #1;
    check("mem_wb_data", 32'(wb_data), 32'hBEEF);
    tick();
    drive_wb(3, 1, 2'b10, 16'hC0DE);
    #1;
    check("regb_wb_data", 32'(wb_data), 32'hC0DE);
    tick();
    idle_wb();
    drain("sel_array");

    // Reserved select never writes, never bypasses
    drive_wb(1, 2, 2'b11, 16'hDEAD);
    W4 = 16'hDEAD;
    set_ra(6);
    #1;
    check("rsv_wb_valid", 32'(wb_valid), 32'h0);
    check("rsv_wb_data", 32'(wb_data), 32'h0);
    check("rsv_no_bypass", 32'(Regaout), 32'h1234);
    tick();
    idle_wb();
    #1;
    check("rsv_unchanged", 32'(Regaout), 32'h1234);

    // Window clear: exactly four busy cycles, mid-clear request ignored
    fill_window(2, 16'hAAAA);
    drain("fill_w2");
    clr_win = 1'b1;
    clr_idx = 2'd2;
    #1;
    check("clr_busy_before", 32'(busy), 32'h0);
    tick();
    clr_win = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("clr_busy_c%0d", c), 32'(busy), 32'h1);
      if (c == 1) begin
        clr_win = 1'b1;
        clr_idx = 2'd0;
      end
      tick();
      clr_win = 1'b0;
    end
    check("clr_busy_after", 32'(busy), 32'h0);
    check_all("clr_rd");
    set_ra(8);
    #1;
    check("clr_w2_zero", 32'(Regaout), 32'h0);
    set_ra(3);
    #1;
    check("clr_w0_kept", 32'(Regaout), 32'hBEEF);

    // Collision: writeback to the address being cleared wins; other writes proceed
    fill_window(2, 16'hAAAA);
    drain("refill_w2");
    clr_win = 1'b1;
    clr_idx = 2'd2;
    tick();
    clr_win = 1'b0;
    tick();
    drive_wb(2, 1, 2'b00, 16'h5555);
    tick();
    drive_wb(3, 0, 2'b00, 16'h7777);
    tick();
    idle_wb();
    waited = 0;
    while (busy && waited < 8) begin
      tick();
      waited++;
    end
    check("coll_busy_bound", 32'(busy), 32'h0);
    drain("coll_array");
    check_all("coll_rd");

    // Reset mid-clear aborts the clear and discards a concurrent writeback
    clr_win = 1'b1;
    clr_idx = 2'd1;
    tick();
    clr_win = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    drive_wb(0, 0, 2'b00, 16'h9999);
    void'(exp_addr_q.pop_back());
    void'(exp_data_q.pop_back());
    #1;
    check("rst_wb_valid", 32'(wb_valid), 32'h1);
    check("rst_wb_data", 32'(wb_data), 32'h9999);
    tick();
    rst = 1'b0;
    idle_wb();
    check("rst_busy", 32'(busy), 32'h0);
    check_all_zero("rst_rd");
    tick();
    check("rst_busy_stay", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter DATA_W, 16, datapath and register width.
REQ-002 Parameter NWIN, 4, number of register windows.
REQ-003 Parameter NREG, 4, registers per window.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 Instout  in  16  writeback-stage instruction; destination index = Instout[3:2].
REQ-007 W4  in  16  ALU result from the MEM/WB stage.
REQ-008 Memoryout  in  16  load data from the MEM/WB stage.
REQ-009 Regbout  in  16  register-B pass-through from the MEM/WB stage.
REQ-010 RegWriteo4  in  1  write enable from the MEM/WB stage.
REQ-011 RegDatao4  in  2  source select: 00 W4, 01 Memoryout, 10 Regbout, 11 reserved.
REQ-012 WindowRout  in  2  destination window.
REQ-013 clr_win  in  1  one-cycle request to clear one window.
REQ-014 clr_idx  in  2  window to clear, sampled with clr_win.
REQ-015 ra_win, ra_idx / rb_win, rb_idx  in  2 each  read-port window and index, A and B.
REQ-016 Regaout, Regbrd  out  16 each  read data, A and B.
REQ-017 wb_data  out  16  selected writeback value, for forwarding.
REQ-018 wb_valid  out  1  high when a writeback write occurs this cycle.
REQ-019 busy  out  1  high while a window clear is in progress.

Function
REQ-020 Storage SHALL be NWIN*NREG words of DATA_W bits; physical address = {window, index}.
REQ-021 wb_data SHALL be the combinational mux of REQ-011; for code 11, wb_data = 0.
REQ-022 wb_valid SHALL be RegWriteo4 AND RegDatao4 != 11; code 11 SHALL never write.
REQ-023 When wb_valid, mem[{WindowRout, Instout[3:2]}] SHALL take wb_data at the next posedge (1-cycle latency).
REQ-024 Read ports SHALL be combinational, zero latency.
REQ-025 Bypass: when wb_valid and a read address equals the write address, that port SHALL return wb_data in the same cycle.
REQ-026 FSM states SHALL be IDLE and CLEAR; a 2-bit counter cnt is used.
REQ-027 IDLE: clr_win=1 -> CLEAR; latch clr_idx; cnt=0; busy asserted from the next cycle.
REQ-028 CLEAR: each cycle write 0 to mem[{latched window, cnt}], then increment cnt; at cnt=3, write and return to IDLE (4 cycles total).
REQ-029 busy SHALL equal (state == CLEAR).
REQ-030 clr_win while in CLEAR SHALL be ignored; no queuing.
REQ-031 Writeback and clear to the same address in the same cycle: writeback SHALL win.
REQ-032 Writebacks to other addresses during CLEAR SHALL proceed normally; the block never stalls writeback.
REQ-033 Reads during CLEAR SHALL return array contents (plus REQ-025 bypass); there is no clear-bypass.

Reset
REQ-034 rst=1 at posedge SHALL zero all registers, set state IDLE and cnt=0; the next cycle busy=0 and Regaout=Regbrd=0 (absent a writeback bypass).
REQ-035 rst SHALL take priority over writeback and clear; rst during CLEAR SHALL abort the clear.
REQ-036 wb_data and wb_valid SHALL stay combinational from their inputs during rst; no write is committed.

Structure
REQ-037 Shared package wb_pkg SHALL hold DATA_W, NWIN, NREG, the RegData encodings (SEL_ALU, SEL_MEM, SEL_REGB, SEL_NONE) and the FSM state enum.
REQ-038 Storage SHALL be a sub-module regfile_array: 1 write port, 2 async read ports, synchronous reset; the bypass and FSM live in writeback_regfile.

Verification
REQ-039 The bench SHALL cover the following scenarios.
- Reset: rst 1 cycle -> all 16 addresses read 0, busy=0.
- ALU write: Instout[3:2]=2, WindowRout=1, RegDatao4=00, W4=0x1234, RegWriteo4=1 -> wb_valid=1; ra=(1,2) reads 0x1234 in the same cycle (bypass) and after the edge (array).
- Select/reserved: RegDatao4=01, Memoryout=0xBEEF -> writes 0xBEEF; RegDatao4=11 with RegWriteo4=1 -> wb_valid=0, wb_data=0, target unchanged.
- Clear: fill window 2 with 0xAAAA, then clr_win with clr_idx=2 -> busy high for exactly 4 cycles; window 2 reads 0; windows 0, 1, 3 unchanged; second clr_win mid-clear ignored.
- Collision: during CLEAR at cnt=1, writeback of 0x5555 to (2,1) -> (2,1) reads 0x5555 afterwards.
- Reset mid-clear: rst at cnt=2 -> state IDLE, busy=0, all registers 0.
